sobel_window_buffer: RTL

- Parametrised 3x3 window generator for the Sobel path. Replaces the fixed-size buffer.
- Accepts a raster-order grayscale stream. Emits one registered 3x3 neighbourhood per centre pixel, with the centre row/column and an end-of-frame marker.
- Adds selectable border handling (interior-only or zero-padded), a flush phase with input backpressure, and automatic frame-to-frame restart.
- Sits between the grayscale converter and the Sobel gradient stage.

---
 rtl/sobel_window_buffer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sobel_window_buffer.sv
// 3x3 neighbourhood generator for the Sobel path: raster-order pixels in, one
// registered window per centre out, with optional zero-padded borders and a flush phase.
module sobel_window_buffer #(
  parameter int DATA_W      = 8,
  parameter int IMG_W       = 6,
  parameter int IMG_H       = 6,
  parameter int BORDER_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        grayscale_i,
  input  logic                     done_i,
  output logic                     ready_o,
  output logic [DATA_W-1:0]        d0_o,
  output logic [DATA_W-1:0]        d1_o,
  output logic [DATA_W-1:0]        d2_o,
  output logic [DATA_W-1:0]        d3_o,
  output logic [DATA_W-1:0]        d4_o,
  output logic [DATA_W-1:0]        d5_o,
  output logic [DATA_W-1:0]        d6_o,
  output logic [DATA_W-1:0]        d7_o,
  output logic [DATA_W-1:0]        d8_o,
  output logic [$clog2(IMG_H)-1:0] row_o,
  output logic [$clog2(IMG_W)-1:0] col_o,
  output logic                     done_o,
  output logic                     eof_o
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int IRW = $clog2(IMG_H + 2);
  localparam logic [CW-1:0]  COL_LAST    = CW'(IMG_W - 1);
  localparam logic [CW-1:0]  COL_PEN     = CW'(IMG_W - 2);
  localparam logic [RW-1:0]  ROW_LAST    = RW'(IMG_H - 1);
  localparam logic [RW-1:0]  ROW_PEN     = RW'(IMG_H - 2);
  localparam logic [IRW-1:0] IN_ROW_LAST = IRW'(IMG_H - 1);
  localparam logic [0:0]     ST_RUN      = 1'b0;
  localparam logic [0:0]     ST_FLUSH    = 1'b1;

  function automatic logic [DATA_W-1:0] pad(input logic [DATA_W-1:0] v, input logic zero);
    return zero ? '0 : v;
  endfunction

  logic [0:0]        state;
  logic [IRW-1:0]    in_row;
  logic [CW-1:0]     in_col;
  logic [RW-1:0]     cen_row;
  logic [CW-1:0]     cen_col;
  logic [DATA_W-1:0] line_a [IMG_W];
  logic [DATA_W-1:0] line_b [IMG_W];
  logic [DATA_W-1:0] tap_l_p0 [3];
  logic [DATA_W-1:0] tap_c_p0 [3];
  logic [DATA_W-1:0] new_col [3];

  logic accept, shift, cen_act, emit, eof_hit, last_in, last_cen;
  logic at_left, at_right, at_top, at_bot;

  assign ready_o = (state == ST_RUN);

  always_comb begin
    accept   = (state == ST_RUN) && done_i;
    shift    = accept || (state == ST_FLUSH);
    // Centre trails input by IMG_W+1 positions.
    cen_act  = (in_row > IRW'(1)) || ((in_row == IRW'(1)) && (in_col != '0));
    at_left  = (cen_col == '0);
    at_right = (cen_col == COL_LAST);
    at_top   = (cen_row == '0);
    at_bot   = (cen_row == ROW_LAST);
    last_in  = accept && (in_row == IN_ROW_LAST) && (in_col == COL_LAST);
    last_cen = at_bot && at_right;
    new_col[0] = line_b[in_col];
    new_col[1] = line_a[in_col];
    new_col[2] = (state == ST_FLUSH) ? '0 : grayscale_i;
    if (BORDER_MODE == 1) begin
      emit    = cen_act;
      eof_hit = last_cen;
    end else begin
      emit    = cen_act && !at_left && !at_right && !at_top && !at_bot;
      eof_hit = (cen_row == ROW_PEN) && (cen_col == COL_PEN);
    end
  end

  // Control: input position, centre position, RUN/FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      in_row  <= '0;
      in_col  <= '0;
      cen_row <= '0;
      cen_col <= '0;
    end else if (shift) begin
      if (((BORDER_MODE == 0) && last_in) || ((state == ST_FLUSH) && last_cen)) begin
        state   <= ST_RUN;
        in_row  <= '0;
        in_col  <= '0;
        cen_row <= '0;
        cen_col <= '0;
      end else begin
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= in_row + IRW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
        if (cen_act) begin
          if (at_right) begin
            cen_col <= '0;
            cen_row <= cen_row + RW'(1);
          end else begin
            cen_col <= cen_col + CW'(1);
          end
        end
        if (last_in) state <= ST_FLUSH;
      end
    end
  end

  // Stage p0: line buffers and the two older tap columns (data only, no reset).
  always_ff @(posedge clk) begin
    if (shift) begin
      line_b[in_col] <= line_a[in_col];
      line_a[in_col] <= new_col[2];
      for (int i = 0; i < 3; i++) begin
        tap_l_p0[i] <= tap_c_p0[i];
        tap_c_p0[i] <= new_col[i];
      end
    end
  end

  // Output stage: padding is derived from the centre position, never from memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_o <= 1'b0;
      eof_o  <= 1'b0;
      d0_o   <= '0;
      d1_o   <= '0;
      d2_o   <= '0;
      d3_o   <= '0;
      d4_o   <= '0;
      d5_o   <= '0;
      d6_o   <= '0;
      d7_o   <= '0;
      d8_o   <= '0;
      row_o  <= '0;
      col_o  <= '0;
    end else begin
      done_o <= shift && emit;
      eof_o  <= shift && emit && eof_hit;
      if (shift && emit) begin
        d0_o  <= pad(tap_l_p0[0], at_left || at_top);
        d1_o  <= pad(tap_c_p0[0], at_top);
        d2_o  <= pad(new_col[0], at_right || at_top);
        d3_o  <= pad(tap_l_p0[1], at_left);
        d4_o  <= tap_c_p0[1];
        d5_o  <= pad(new_col[1], at_right);
        d6_o  <= pad(tap_l_p0[2], at_left || at_bot);
        d7_o  <= pad(tap_c_p0[2], at_bot);
        d8_o  <= pad(new_col[2], at_right || at_bot);
        row_o <= cen_row;
        col_o <= cen_col;
      end
    end
  end

endmodule
